// File: rtl/upstream_pkg.sv
// Shared types and default constants for the upstream limit engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default parameter values, request struct.
package upstream_pkg;

  localparam int unsigned DEF_N_CLIENTS   = 32;
  localparam int unsigned DEF_ID_W        = $clog2(DEF_N_CLIENTS);
  localparam int unsigned DEF_AMT_W       = 32;
  localparam int unsigned DEF_DEFAULT_MAX = 0;
  localparam int unsigned DEF_CNT_W       = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // One request as seen on the inbound bus, sized for the default build.
  typedef struct packed {
    logic                 order;
    logic                 max;
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_AMT_W-1:0] amount;
  } req_t;

endpackage

// File: rtl/upstream_limit_engine_if.sv
// Request/response bundle between the stimulus side and the limit engine.
// Latency: n/a (wires only).
// Backpressure: in_ready low means requests are dropped and flagged.
// master: drives requests, observes results. slave: the engine.
interface upstream_limit_engine_if #(
  parameter int ID_W  = 5,
  parameter int AMT_W = 32
);
  logic             new_order;
  logic             new_max;
  logic [ID_W-1:0]  client_id;
  logic [AMT_W-1:0] amount;
  logic             clear_req;
  logic             in_ready;
  logic             order_accept;
  logic             order_reject;
  logic             thenewmax;
  logic [AMT_W-1:0] accumulated_orders;
  logic [AMT_W-1:0] max_to_trade;
  logic             proto_err;

  modport master (
    output new_order, new_max, client_id, amount, clear_req,
    input  in_ready, order_accept, order_reject, thenewmax,
           accumulated_orders, max_to_trade, proto_err
  );

  modport slave (
    input  new_order, new_max, client_id, amount, clear_req,
    output in_ready, order_accept, order_reject, thenewmax,
           accumulated_orders, max_to_trade, proto_err
  );
endinterface

// File: rtl/upstream_client_bank.sv
// Per-client accumulator and limit storage with a combinational read port.
// Latency: read is combinational; writes land on the next clk edge.
// Backpressure: none; the caller guarantees write ids are in range.
// Ports: rd_id -> rd_acc/rd_max; acc write port, max write port, clear-sweep write.
module upstream_client_bank #(
  parameter int          N_CLIENTS   = 32,
  parameter int          ID_W        = $clog2(N_CLIENTS),
  parameter int          AMT_W       = 32,
  parameter int unsigned DEFAULT_MAX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ID_W-1:0]  rd_id,
  output logic [AMT_W-1:0] rd_acc,
  output logic [AMT_W-1:0] rd_max,
  input  logic             acc_we,
  input  logic [ID_W-1:0]  acc_wid,
  input  logic [AMT_W-1:0] acc_wdat,
  input  logic             max_we,
  input  logic [ID_W-1:0]  max_wid,
  input  logic [AMT_W-1:0] max_wdat,
  input  logic             clr_we,
  input  logic [ID_W-1:0]  clr_idx
);

  logic [AMT_W-1:0] acc_q [N_CLIENTS];
  logic [AMT_W-1:0] acc_d [N_CLIENTS];
  logic [AMT_W-1:0] max_q [N_CLIENTS];
  logic [AMT_W-1:0] max_d [N_CLIENTS];
  logic [ID_W:0]    rd_id_ext;

  // Ids past the last slot exist only for non-power-of-two banks; read as zero.
  assign rd_id_ext = {1'b0, rd_id};
  assign rd_acc    = (rd_id_ext < (ID_W+1)'(N_CLIENTS)) ? acc_q[rd_id] : '0;
  assign rd_max    = (rd_id_ext < (ID_W+1)'(N_CLIENTS)) ? max_q[rd_id] : '0;

  always_comb begin
    acc_d = acc_q;
    max_d = max_q;
    if (acc_we) acc_d[acc_wid] = acc_wdat;
    if (clr_we) acc_d[clr_idx] = '0;
    if (max_we) max_d[max_wid] = max_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        acc_q[i] <= '0;
        max_q[i] <= AMT_W'(DEFAULT_MAX);
      end
    end else begin
      acc_q <= acc_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/upstream_limit_engine.sv
// Per-client order limit checker: books or refuses orders, updates limits, sweeps accumulators clear.
// Latency: result pulse and post-op values registered one cycle after the request edge.
// Backpressure: in_ready low during the clear sweep; requests then are dropped and set proto_err.
// Ports: clk, rst_n, bus (slave modport); with UPSTREAM_STATS_EN also total_accepted/total_rejected.
module upstream_limit_engine
  import upstream_pkg::*;
#(
  parameter int          N_CLIENTS   = DEF_N_CLIENTS,
  parameter int          ID_W        = $clog2(N_CLIENTS),
  parameter int          AMT_W       = DEF_AMT_W,
  parameter int unsigned DEFAULT_MAX = DEF_DEFAULT_MAX
`ifdef UPSTREAM_STATS_EN
  ,parameter int         CNT_W       = DEF_CNT_W
`endif
) (
  input  logic clk,
  input  logic rst_n,
  upstream_limit_engine_if.slave bus
`ifdef UPSTREAM_STATS_EN
  ,output logic [CNT_W-1:0] total_accepted
  ,output logic [CNT_W-1:0] total_rejected
`endif
);

  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] CLEAR = ST_CLEAR;

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic             accept_q, accept_d, reject_q, reject_d, newmax_q, newmax_d;
  logic             proto_err_q, proto_err_d;
  logic [AMT_W-1:0] acc_out_q, acc_out_d, max_out_q, max_out_d;

  logic [AMT_W-1:0] rd_acc, rd_max, eff_max;
  logic [AMT_W:0]   sum;
  logic             req_vld, id_ok, acc_we, max_we, clr_we;

  upstream_client_bank #(
    .N_CLIENTS(N_CLIENTS), .ID_W(ID_W), .AMT_W(AMT_W), .DEFAULT_MAX(DEFAULT_MAX)
  ) u_bank (
    .clk(clk), .rst_n(rst_n),
    .rd_id(bus.client_id), .rd_acc(rd_acc), .rd_max(rd_max),
    .acc_we(acc_we), .acc_wid(bus.client_id), .acc_wdat(sum[AMT_W-1:0]),
    .max_we(max_we), .max_wid(bus.client_id), .max_wdat(bus.amount),
    .clr_we(clr_we), .clr_idx(idx_q)
  );

  assign req_vld = bus.new_order | bus.new_max;
  assign id_ok   = {1'b0, bus.client_id} < (ID_W+1)'(N_CLIENTS);
  // A same-cycle limit update is checked against the new limit.
  assign eff_max = bus.new_max ? bus.amount : rd_max;
  // One extra bit keeps the carry, so a wrapping sum can never look affordable.
  assign sum     = {1'b0, rd_acc} + {1'b0, bus.amount};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    accept_d    = 1'b0;
    reject_d    = 1'b0;
    newmax_d    = 1'b0;
    proto_err_d = proto_err_q;
    acc_out_d   = acc_out_q;
    max_out_d   = max_out_q;
    acc_we      = 1'b0;
    max_we      = 1'b0;
    clr_we      = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      idx_d  = idx_q + ID_W'(1);
      if (req_vld) proto_err_d = 1'b1;
      if (idx_q == ID_W'(N_CLIENTS-1)) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end else begin
      if (req_vld && !id_ok) begin
        proto_err_d = 1'b1;
        reject_d    = bus.new_order;
      end else if (req_vld) begin
        max_we    = bus.new_max;
        newmax_d  = bus.new_max;
        max_out_d = eff_max;
        acc_out_d = rd_acc;
        if (bus.new_order) begin
          if (sum <= {1'b0, eff_max}) begin
            accept_d  = 1'b1;
            acc_we    = 1'b1;
            acc_out_d = sum[AMT_W-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      // Lowest priority: any request this cycle has already been handled above.
      if (bus.clear_req) begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      accept_q    <= 1'b0;
      reject_q    <= 1'b0;
      newmax_q    <= 1'b0;
      proto_err_q <= 1'b0;
      acc_out_q   <= '0;
      max_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      accept_q    <= accept_d;
      reject_q    <= reject_d;
      newmax_q    <= newmax_d;
      proto_err_q <= proto_err_d;
      acc_out_q   <= acc_out_d;
      max_out_q   <= max_out_d;
    end
  end

  assign bus.in_ready           = (state_q == IDLE);
  assign bus.order_accept       = accept_q;
  assign bus.order_reject       = reject_q;
  assign bus.thenewmax          = newmax_q;
  assign bus.accumulated_orders = acc_out_q;
  assign bus.max_to_trade       = max_out_q;
  assign bus.proto_err          = proto_err_q;

`ifdef UPSTREAM_STATS_EN
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, rej_cnt_q, rej_cnt_d;

  // Counters move with the pulse they count and stick at all-ones.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (accept_d && !(&acc_cnt_q)) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    if (reject_d && !(&rej_cnt_q)) rej_cnt_d = rej_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign total_accepted = acc_cnt_q;
  assign total_rejected = rej_cnt_q;
`endif

endmodule

// File: tb/tb_upstream_limit_engine.sv
// Directed and randomized checks of upstream_limit_engine against a behavioural model.
// Latency: results checked 1 time unit after the edge that samples the request.
// Backpressure: in_ready is predicted and checked every step.
module tb_upstream_limit_engine;
  import upstream_pkg::*;

  localparam int N     = 32;
  localparam int ID_W  = 5;
  localparam int AMT_W = 32;
`ifdef UPSTREAM_STATS_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] total_accepted, total_rejected;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upstream_limit_engine_if #(.ID_W(ID_W), .AMT_W(AMT_W)) bus ();

  upstream_limit_engine #(
    .N_CLIENTS(N), .ID_W(ID_W), .AMT_W(AMT_W), .DEFAULT_MAX(0)
`ifdef UPSTREAM_STATS_EN
    ,.CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef UPSTREAM_STATS_EN
    ,.total_accepted(total_accepted)
    ,.total_rejected(total_rejected)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain integers per client, outputs as last reported.
  longint unsigned m_acc [N];
  longint unsigned m_max [N];
  longint unsigned m_out_acc, m_out_max;
  bit  m_proto, e_acc, e_rej, e_nm;
  int  m_clear_rem;
  longint unsigned m_cnt_a, m_cnt_r;
  string cur;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("accept",   bus.order_accept, e_acc);
    check("reject",   bus.order_reject, e_rej);
    check("thenewmax", bus.thenewmax, e_nm);
    check("in_ready", bus.in_ready, (m_clear_rem == 0));
    check("proto_err", bus.proto_err, m_proto);
    check("acc_out",  bus.accumulated_orders, m_out_acc);
    check("max_out",  bus.max_to_trade, m_out_max);
`ifdef UPSTREAM_STATS_EN
    check("total_accepted", total_accepted, m_cnt_a);
    check("total_rejected", total_rejected, m_cnt_r);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_max[i] = 0;
    end
    m_out_acc = 0; m_out_max = 0; m_proto = 0; m_clear_rem = 0;
    e_acc = 0; e_rej = 0; e_nm = 0; m_cnt_a = 0; m_cnt_r = 0;
  endtask

  task automatic step(input bit o, input bit mx, input int id, input longint unsigned amt, input bit clr);
    req_t r;
    r.order = o; r.max = mx; r.id = id[ID_W-1:0]; r.amount = amt[AMT_W-1:0];
    bus.new_order = r.order; bus.new_max = r.max; bus.client_id = r.id;
    bus.amount = r.amount; bus.clear_req = clr;
    @(posedge clk); #1;
    bus.new_order = 0; bus.new_max = 0; bus.clear_req = 0;
    e_acc = 0; e_rej = 0; e_nm = 0;
    if (m_clear_rem > 0) begin
      if (o || mx) m_proto = 1;
      m_clear_rem--;
    end else begin
      if (mx) begin m_max[id] = amt; e_nm = 1; end
      if (o) begin
        if (m_acc[id] + amt <= m_max[id]) begin m_acc[id] += amt; e_acc = 1; end
        else e_rej = 1;
      end
      if (o || mx) begin m_out_acc = m_acc[id]; m_out_max = m_max[id]; end
      if (clr) begin
        m_clear_rem = N;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
      end
    end
`ifdef UPSTREAM_STATS_EN
    if (e_acc && m_cnt_a < (1 << CNT_W) - 1) m_cnt_a++;
    if (e_rej && m_cnt_r < (1 << CNT_W) - 1) m_cnt_r++;
`endif
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    cur = "reset";
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic random_steps(input int n);
    for (int k = 0; k < n; k++) begin
      bit o, mx, clr;
      longint unsigned amt;
      int sel;
      o   = ($urandom_range(0, 2) != 0);
      mx  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 9);
      if (mx) amt = (sel == 9) ? 64'hFFFF_FFFF : longint'($urandom_range(0, 1000));
      else if (sel < 6) amt = longint'($urandom_range(1, 200));
      else if (sel < 8) amt = 0;
      else amt = longint'($urandom);
      step(o, mx, $urandom_range(0, N - 1), amt, clr);
    end
  endtask

  initial begin
    bus.new_order = 0; bus.new_max = 0; bus.client_id = '0;
    bus.amount = '0; bus.clear_req = 0;
    do_reset();

    cur = "setmax3";   step(0, 1, 3, 100, 0);
    cur = "order60";   step(1, 0, 3, 60, 0);
    cur = "order40";   step(1, 0, 3, 40, 0);
    cur = "order1";    step(1, 0, 3, 1, 0);
    cur = "setmax5";   step(0, 1, 5, 64'hFFFF_FFFF, 0);
    cur = "fill5";     step(1, 0, 5, 64'hFFFF_FFF0, 0);
    cur = "carry5";    step(1, 0, 5, 64'h20, 0);
    cur = "both7";     step(1, 1, 7, 50, 0);
    cur = "lower3";    step(0, 1, 3, 50, 0);
    cur = "zero3";     step(1, 0, 3, 0, 0);
    cur = "one3";      step(1, 0, 3, 1, 0);
    cur = "zero5";     step(1, 0, 5, 0, 0);

    cur = "rand1";     random_steps(400);
    cur = "drain";     while (m_clear_rem > 0) step(0, 0, 0, 0, 0);

    do_reset();
    cur = "prefill";
    for (int i = 0; i < N; i++) step(1, 1, i, 10 + i, 0);
    cur = "clear_req"; step(1, 0, 4, 5, 1);
    for (int k = 0; k < N; k++) begin
      cur = "sweep";
      if (k == 10) step(1, 0, 3, 5, 0);
      else step(0, 0, 0, 0, 0);
    end
    cur = "postclear";
    for (int i = 0; i < N; i++) step(1, 0, i, 0, 0);

    cur = "clr_again"; step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cur = "midsweep_rst";
    do_reset();
    cur = "after_rst"; step(1, 0, 2, 0, 0);
    cur = "after_rst1"; step(1, 0, 2, 1, 0);

    cur = "rand2";     random_steps(300);

`ifdef UPSTREAM_STATS_EN
    cur = "drain2";    while (m_clear_rem > 0) step(0, 0, 0, 0, 0);
    do_reset();
    cur = "stats";     step(0, 1, 0, 1000, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 10, 0);
    check("sat_accept", total_accepted, 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
